// File: rtl/pipe_stage_chain_pkg.sv
// Shared types and sizing helpers for the elastic pipeline-register chain.
package pipe_pkg;

    localparam int MAX_STAGES = 16;

    typedef struct packed {
        logic valid;
        logic stall;
        logic flush;
    } stage_ctl_t;

    function automatic int occ_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Producer/consumer handshake bundle at the two ends of the pipeline chain.
interface pipe_stage_chain_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             flush_in;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output in_valid, in_data, flush_in, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, flush_in, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_chain_stage.sv
// One elastic register stage: valid + payload with per-stage hold and kill.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  stage_ctl_t       ctl,
    input  logic [WIDTH-1:0] load_data,
    input  logic             next_ready,
    output logic             ready,
    output logic             offer,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    logic v_eff;
    logic adv;

    // A killed entry neither advances nor holds its slot.
    assign v_eff = valid & ~ctl.flush;
    assign offer = v_eff & ~ctl.stall;
    assign adv   = offer & next_ready;
    assign ready = ~v_eff | adv;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (ready) begin
            valid <= ctl.valid;
            if (ctl.valid) begin
                data <= load_data;
            end
        end
    end
endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised elastic pipeline-register chain with per-stage stall/flush,
// occupancy tracking and a saturating input-stall counter.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int CNT_W  = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    pipe_stage_chain_if.slave               bus,
    input  logic [STAGES-1:0]               stall_req,
    input  logic [STAGES-1:0]               flush_mask,
    output logic [STAGES-1:0]               stage_valid,
    output logic [STAGES*WIDTH-1:0]         stage_data,
    output logic [occ_width(STAGES)-1:0]    occupancy,
    output logic [CNT_W-1:0]                stall_cnt
);
    localparam int OCC_W = occ_width(STAGES);

    logic [STAGES-1:0] ready;
    logic [STAGES-1:0] offer;
    logic [STAGES-1:0] incoming;
    logic [STAGES-1:0] next_ready;
    logic [STAGES-1:0] next_valid;
    logic [OCC_W-1:0]  occ_next;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        stage_ctl_t       ctl;
        logic [WIDTH-1:0] load_data;

        // Stage i only samples its input when ready, so offer[i-1] is
        // equivalent to adv[i-1] at the point of use.
        if (i == 0) begin : g_head
            assign incoming[i] = bus.in_valid & ~bus.flush_in;
            assign load_data   = bus.in_data;
        end else begin : g_body
            assign incoming[i] = offer[i-1];
            assign load_data   = stage_data[(i-1)*WIDTH +: WIDTH];
        end

        if (i == STAGES - 1) begin : g_tail
            assign next_ready[i] = bus.out_ready;
        end else begin : g_mid
            assign next_ready[i] = ready[i+1];
        end

        assign ctl = '{valid: incoming[i], stall: stall_req[i], flush: flush_mask[i]};

        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .ctl        (ctl),
            .load_data  (load_data),
            .next_ready (next_ready[i]),
            .ready      (ready[i]),
            .offer      (offer[i]),
            .valid      (stage_valid[i]),
            .data       (stage_data[i*WIDTH +: WIDTH])
        );
    end

    assign bus.in_ready  = ready[0];
    assign bus.out_valid = offer[STAGES-1];
    assign bus.out_data  = stage_data[(STAGES-1)*WIDTH +: WIDTH];

    assign next_valid = (ready & incoming) | (~ready & stage_valid);

    always_comb begin
        occ_next = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ_next = occ_next + OCC_W'(next_valid[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occupancy <= '0;
            stall_cnt <= '0;
        end else begin
            occupancy <= occ_next;
            if (bus.in_valid && !ready[0] && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// stage-array reference model that walks the pipe from the output end.
module tb_pipe_stage_chain;
    import pipe_pkg::*;

    localparam int W  = 32;
    localparam int S  = 4;
    localparam int SW = S * W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_stage_chain_if #(.WIDTH(W)) bus ();
    pipe_stage_chain_if #(.WIDTH(W)) bus2 ();

    logic [S-1:0]  stall_req, flush_mask, stage_valid, stage_valid2;
    logic [SW-1:0] stage_data, stage_data2;
    logic [2:0]    occupancy, occupancy2;
    logic [15:0]   stall_cnt;
    logic [3:0]    stall_cnt2;

    pipe_stage_chain #(.WIDTH(W), .STAGES(S), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .stall_req(stall_req), .flush_mask(flush_mask),
        .stage_valid(stage_valid), .stage_data(stage_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_chain #(.WIDTH(W), .STAGES(S), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus2),
        .stall_req('0), .flush_mask('0),
        .stage_valid(stage_valid2), .stage_data(stage_data2),
        .occupancy(occupancy2), .stall_cnt(stall_cnt2)
    );

    int n_chk = 0;
    int n_err = 0;

    bit             m_valid [S];
    logic [W-1:0]   m_data  [S];
    int             m_cnt;
    bit             open_s  [S];
    bit             moves   [S];
    bit             e_in_ready, e_out_valid;
    logic [W-1:0]   exits [$];

    task automatic chk(input string tag, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // An entry leaves its slot if it is alive, not held, and the slot ahead
    // will be free by the edge; that freedom ripples back toward the input.
    function automatic void model_comb();
        bit space;
        bit alive;
        space = bus.out_ready;
        for (int i = S - 1; i >= 0; i--) begin
            alive     = m_valid[i] && !flush_mask[i];
            moves[i]  = alive && !stall_req[i] && space;
            open_s[i] = !alive || moves[i];
            space     = open_s[i];
        end
        e_in_ready  = space;
        e_out_valid = m_valid[S-1] && !flush_mask[S-1] && !stall_req[S-1];
    endfunction

    function automatic void model_edge();
        bit inc;
        if (!rst_n) begin
            for (int i = 0; i < S; i++) begin
                m_valid[i] = 1'b0;
                m_data[i]  = '0;
            end
            m_cnt = 0;
        end else begin
            if (bus.in_valid && !e_in_ready && m_cnt < 65535) m_cnt++;
            for (int i = S - 1; i >= 0; i--) begin
                if (open_s[i]) begin
                    inc = (i == 0) ? (bus.in_valid && !bus.flush_in) : moves[i-1];
                    m_valid[i] = inc;
                    if (inc) m_data[i] = (i == 0) ? bus.in_data : m_data[i-1];
                end
            end
        end
    endfunction

    // Called just after the falling edge with inputs already driven.
    task automatic step();
        logic [S-1:0]  ev;
        logic [SW-1:0] ed;
        int            occ;
        #1;
        model_comb();
        occ = 0;
        for (int i = 0; i < S; i++) begin
            ev[i]        = m_valid[i];
            ed[i*W +: W] = m_data[i];
            occ += int'(m_valid[i]);
        end
        chk("in_ready",    SW'(bus.in_ready),  SW'(e_in_ready));
        chk("out_valid",   SW'(bus.out_valid), SW'(e_out_valid));
        chk("out_data",    SW'(bus.out_data),  SW'(m_data[S-1]));
        chk("stage_valid", SW'(stage_valid),   SW'(ev));
        chk("stage_data",  stage_data,         ed);
        chk("occupancy",   SW'(occupancy),     SW'(occ));
        chk("stall_cnt",   SW'(stall_cnt),     SW'(m_cnt));
        if (bus.out_valid && bus.out_ready) exits.push_back(bus.out_data);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush_in  = 1'b0;
        bus.out_ready = 1'b1;
        stall_req     = '0;
        flush_mask    = '0;
    endtask

    task automatic reset_cycles(input int n);
        idle();
        rst_n = 1'b0;
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < S; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = '0;
        end
        m_cnt = 0;
        idle();
        bus2.in_valid  = 1'b0;
        bus2.in_data   = '0;
        bus2.flush_in  = 1'b0;
        bus2.out_ready = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);

        // Streaming
        reset_cycles(2);
        for (int k = 0; k < 12; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = W'(k + 1);
            step();
            if (k == 2) chk("stream_latency", SW'(bus.out_valid), SW'(0));
            if (k >= 3) begin
                chk("stream_valid", SW'(bus.out_valid), SW'(1));
                chk("stream_data",  SW'(bus.out_data),  SW'(k - 2));
            end
        end
        chk("stream_occ", SW'(occupancy), SW'(4));
        chk("stream_cnt", SW'(stall_cnt), SW'(0));

        // Bubble insertion behind a stalled stage
        reset_cycles(1);
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = W'(32'hA + k);
            step();
        end
        for (int k = 0; k < 2; k++) begin
            stall_req    = 4'b0010;
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hD;
            #1;
            chk("bubble_in_ready", SW'(bus.in_ready), SW'(0));
            step();
            chk("bubble_s2", SW'(stage_valid[2]), SW'(0));
        end
        chk("bubble_cnt", SW'(stall_cnt), SW'(2));
        stall_req = '0;
        exits.delete();
        step();
        bus.in_valid = 1'b0;
        repeat (6) step();
        chk("bubble_exits", SW'(exits.size()), SW'(3));
        if (exits.size() == 3) begin
            chk("bubble_x0", SW'(exits[0]), SW'(32'hB));
            chk("bubble_x1", SW'(exits[1]), SW'(32'hC));
            chk("bubble_x2", SW'(exits[2]), SW'(32'hD));
        end

        // Flush wins over stall
        reset_cycles(1);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = W'(32'h13 - k);
            step();
        end
        chk("flush_full", SW'(occupancy), SW'(4));
        bus.in_valid = 1'b0;
        flush_mask   = 4'b0011;
        stall_req    = 4'b0010;
        step();
        chk("flush_occ2",  SW'(occupancy),   SW'(2));
        chk("flush_valid", SW'(stage_valid), SW'(4'b1100));
        flush_mask    = '0;
        stall_req     = '0;
        bus.out_ready = 1'b1;
        exits.delete();
        step();
        chk("flush_occ1", SW'(occupancy), SW'(1));
        repeat (3) step();
        chk("flush_exits", SW'(exits.size()), SW'(2));
        if (exits.size() == 2) begin
            chk("flush_x0", SW'(exits[0]), SW'(32'h13));
            chk("flush_x1", SW'(exits[1]), SW'(32'h12));
        end

        // Backpressure
        reset_cycles(1);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = W'(32'h20 + k);
            step();
        end
        bus.in_data = 32'h24;
        #1;
        chk("bp_in_ready", SW'(bus.in_ready), SW'(0));
        repeat (3) step();
        chk("bp_hold", stage_data, {32'h20, 32'h21, 32'h22, 32'h23});
        bus.out_ready = 1'b1;
        exits.delete();
        for (int k = 0; k < 12; k++) begin
            bus.in_data = W'(32'h24 + k);
            step();
        end
        bus.in_valid = 1'b0;
        repeat (5) step();
        chk("bp_exits", SW'(exits.size()), SW'(16));
        for (int k = 0; k < exits.size(); k++) chk("bp_order", SW'(exits[k]), SW'(32'h20 + k));

        // Reset while full and stalled
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.in_data = W'(32'h40 + k);
            step();
        end
        stall_req = 4'hF;
        repeat (2) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_valid", SW'(stage_valid), SW'(0));
        chk("rst_data",  stage_data,       SW'(0));
        chk("rst_occ",   SW'(occupancy),   SW'(0));
        chk("rst_cnt",   SW'(stall_cnt),   SW'(0));

        // Saturation of a 4-bit stall counter
        reset_cycles(1);
        bus2.in_valid  = 1'b1;
        bus2.out_ready = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            bus2.in_data = W'(c);
            step();
            if (c == 4)  chk("sat_c4",  SW'(stall_cnt2), SW'(0));
            if (c == 12) chk("sat_c12", SW'(stall_cnt2), SW'(8));
            if (c == 20) chk("sat_c20", SW'(stall_cnt2), SW'(4'hF));
        end
        bus2.in_valid = 1'b0;

        // Randomized traffic
        reset_cycles(1);
        for (int n = 0; n < 3000; n++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = $urandom;
            bus.flush_in  = ($urandom_range(0, 15) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            for (int b = 0; b < S; b++) begin
                stall_req[b]  = ($urandom_range(0, 4) == 0);
                flush_mask[b] = ($urandom_range(0, 11) == 0);
            end
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
